// File: rtl/cache_pkg.sv
// Shared types and address helpers for the direct-mapped write-back data cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    REFILL = 2'd2
  } state_e;

  function automatic int unsigned off_w(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned words, input int unsigned lines);
    return 30 - $clog2(words) - $clog2(lines);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int unsigned off,
                                           input int unsigned idx);
    return a >> (2 + off + idx);
  endfunction

  function automatic logic [31:0] addr_idx(input logic [31:0] a, input int unsigned off,
                                           input int unsigned idx);
    return (a >> (2 + off)) & ((32'd1 << idx) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_off(input logic [31:0] a, input int unsigned off);
    return (a >> 2) & ((32'd1 << off) - 32'd1);
  endfunction

endpackage

// File: rtl/cache_line.sv
// One cache line: WORDS data words plus tag, valid and dirty bits.
module cache_line
  import cache_pkg::*;
#(
  parameter int unsigned WORDS = 4,
  parameter int unsigned TAGW  = 24
) (
  input  logic                         CLK,
  input  logic                         Reset,
  input  logic                         word_we,
  input  logic [off_w(WORDS)-1:0]      word_sel,
  input  logic [31:0]                  word_wd,
  input  logic                         meta_we,
  input  logic [TAGW-1:0]              meta_tag,
  input  logic                         dirty_set,
  output logic                         valid,
  output logic                         dirty,
  output logic [TAGW-1:0]              tag,
  output logic [WORDS-1:0][31:0]       data
);

  logic [WORDS-1:0][31:0] data_q, data_d;
  logic [TAGW-1:0]        tag_q, tag_d;
  logic                   valid_q, valid_d;
  logic                   dirty_q, dirty_d;

  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (word_we) data_d[word_sel] = word_wd;
    if (dirty_set) dirty_d = 1'b1;
    // A completed refill installs the new tag and leaves the line clean.
    if (meta_we) begin
      tag_d   = meta_tag;
      valid_d = 1'b1;
      dirty_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    data_q <= data_d;
    tag_q  <= tag_d;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  assign valid = valid_q;
  assign dirty = dirty_q;
  assign tag   = tag_q;
  assign data  = data_q;

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache with a word-serial writeback/refill FSM.
module dcache_wb
  import cache_pkg::*;
#(
  parameter int unsigned WORDS = 4,
  parameter int unsigned LINES = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        CpuReq,
  input  logic        CpuWE,
  input  logic [31:0] CpuAddr,
  input  logic [31:0] CpuWD,
  output logic [31:0] CpuRD,
  output logic        Stall,
  output logic        MemReq,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWD,
  input  logic [31:0] MemRD,
  input  logic        MemAck
);

  localparam int unsigned OFF  = off_w(WORDS);
  localparam int unsigned IDX  = idx_w(LINES);
  localparam int unsigned TAGW = tag_w(WORDS, LINES);

  logic [TAGW-1:0] a_tag;
  logic [IDX-1:0]  a_idx;
  logic [OFF-1:0]  a_off;

  assign a_tag = TAGW'(addr_tag(CpuAddr, OFF, IDX));
  assign a_idx = IDX'(addr_idx(CpuAddr, OFF, IDX));
  assign a_off = OFF'(addr_off(CpuAddr, OFF));

  logic [LINES-1:0]       valid_v, dirty_v;
  logic [TAGW-1:0]        tag_v  [LINES];
  logic [WORDS-1:0][31:0] data_v [LINES];

  logic                   word_we, meta_we, dirty_set;
  logic [OFF-1:0]         word_sel;
  logic [31:0]            word_wd;

  for (genvar i = 0; i < LINES; i++) begin : g_line
    cache_line #(.WORDS(WORDS), .TAGW(TAGW)) u_line (
      .CLK       (CLK),
      .Reset     (Reset),
      .word_we   (word_we && (a_idx == IDX'(i))),
      .word_sel  (word_sel),
      .word_wd   (word_wd),
      .meta_we   (meta_we && (a_idx == IDX'(i))),
      .meta_tag  (a_tag),
      .dirty_set (dirty_set && (a_idx == IDX'(i))),
      .valid     (valid_v[i]),
      .dirty     (dirty_v[i]),
      .tag       (tag_v[i]),
      .data      (data_v[i])
    );
  end

  logic [TAGW-1:0]        line_tag;
  logic [WORDS-1:0][31:0] line_data;
  logic                   line_valid, line_dirty, hit, last;

  assign line_tag   = tag_v[a_idx];
  assign line_data  = data_v[a_idx];
  assign line_valid = valid_v[a_idx];
  assign line_dirty = dirty_v[a_idx];
  assign hit        = CpuReq && line_valid && (line_tag == a_tag);
  assign CpuRD      = line_data[a_off];

  state_e         state_q, state_d;
  logic [OFF-1:0] cnt_q, cnt_d;

  assign last = (cnt_q == OFF'(WORDS - 1));

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    Stall     = 1'b0;
    MemReq    = 1'b0;
    MemWE     = 1'b0;
    MemAddr   = '0;
    MemWD     = '0;
    word_we   = 1'b0;
    word_sel  = a_off;
    word_wd   = CpuWD;
    meta_we   = 1'b0;
    dirty_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          word_we   = CpuWE;
          dirty_set = CpuWE;
        end else if (CpuReq) begin
          Stall   = 1'b1;
          cnt_d   = '0;
          state_d = (line_valid && line_dirty) ? WB : REFILL;
        end
      end
      WB: begin
        Stall   = 1'b1;
        MemReq  = 1'b1;
        MemWE   = 1'b1;
        MemAddr = {line_tag, a_idx, cnt_q, 2'b00};
        MemWD   = line_data[cnt_q];
        if (MemAck) begin
          cnt_d = cnt_q + 1'b1;
          if (last) state_d = REFILL;
        end
      end
      REFILL: begin
        Stall   = 1'b1;
        MemReq  = 1'b1;
        MemAddr = {a_tag, a_idx, cnt_q, 2'b00};
        // Each acked word lands in the line; the last one also commits the tag.
        if (MemAck) begin
          word_we  = 1'b1;
          word_sel = cnt_q;
          word_wd  = MemRD;
          cnt_d    = cnt_q + 1'b1;
          if (last) begin
            meta_we = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed self-checking bench for dcache_wb with a word-serial memory responder.
module tb_dcache_wb;

  logic        CLK, Reset;
  logic        CpuReq, CpuWE;
  logic [31:0] CpuAddr, CpuWD, CpuRD;
  logic        Stall, MemReq, MemWE;
  logic [31:0] MemAddr, MemWD, MemRD;
  logic        MemAck;

  dcache_wb #(.WORDS(4), .LINES(16)) dut (
    .CLK(CLK), .Reset(Reset), .CpuReq(CpuReq), .CpuWE(CpuWE), .CpuAddr(CpuAddr),
    .CpuWD(CpuWD), .CpuRD(CpuRD), .Stall(Stall), .MemReq(MemReq), .MemWE(MemWE),
    .MemAddr(MemAddr), .MemWD(MemWD), .MemRD(MemRD), .MemAck(MemAck)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;
  logic        ack_en;
  int          we_cycles;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rf_q[$], wa_q[$], wd_q[$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory: log completed words at the edge, then present ack/data for the next edge.
  always @(posedge CLK) begin
    if (MemReq && MemAck) begin
      if (MemWE) begin
        mem[MemAddr] = MemWD;
        wa_q.push_back(MemAddr);
        wd_q.push_back(MemWD);
      end else begin
        rf_q.push_back(MemAddr);
      end
    end
    if (MemReq && MemWE) we_cycles++;
    #1;
    MemAck = MemReq && ack_en;
    MemRD  = mem_rd(MemAddr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge CLK);
      cyc++;
      if (!Stall) break;
    end
  endtask

  task automatic clear_logs();
    rf_q.delete(); wa_q.delete(); wd_q.delete();
    we_cycles = 0;
  endtask

  task automatic cpu(input logic we, input logic [31:0] a, input logic [31:0] wd);
    CpuReq = 1'b1; CpuWE = we; CpuAddr = a; CpuWD = wd;
  endtask

  int cyc;
  logic [31:0] hold_addr, hold_wd;

  initial begin
    Reset = 1'b1; CpuReq = 1'b0; CpuWE = 1'b0; CpuAddr = '0; CpuWD = '0;
    MemAck = 1'b0; MemRD = '0; ack_en = 1'b1; we_cycles = 0;
    mem[32'h40] = 32'h1111_1111; mem[32'h44] = 32'h2222_2222;
    mem[32'h48] = 32'h3333_3333; mem[32'h4C] = 32'h4444_4444;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_memreq", {31'd0, MemReq}, 32'd0);
    chk("rst_memwe", {31'd0, MemWE}, 32'd0);
    chk("rst_stall", {31'd0, Stall}, 32'd0);
    @(negedge CLK);
    Reset = 1'b0;
    clear_logs();

    // 1: cold load miss refills 0x40..0x4C
    cpu(1'b0, 32'h40, 32'h0);
    #1 chk("t1_stall", {31'd0, Stall}, 32'd1);
    wait_ready(cyc);
    chk("t1_latency", cyc, 32'd5);
    chk("t1_rd", CpuRD, 32'h1111_1111);
    chk("t1_nrefill", rf_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk("t1_rfaddr", rf_q[i], 32'h40 + 32'(4 * i));

    // 2: store hit then load hit, no memory traffic
    clear_logs();
    cpu(1'b1, 32'h44, 32'hDEAD_BEEF);
    #1 chk("t2_st_stall", {31'd0, Stall}, 32'd0);
    @(negedge CLK);
    cpu(1'b0, 32'h44, 32'h0);
    #1 chk("t2_ld_stall", {31'd0, Stall}, 32'd0);
    chk("t2_ld_rd", CpuRD, 32'hDEAD_BEEF);
    chk("t2_memreq", {31'd0, MemReq}, 32'd0);
    @(negedge CLK);
    cpu(1'b0, 32'h48, 32'h0);
    #1 chk("t2_ld48", CpuRD, 32'h3333_3333);
    @(negedge CLK);

    // 3: dirty conflict miss writes back the old line first
    clear_logs();
    cpu(1'b0, 32'h440, 32'h0);
    wait_ready(cyc);
    chk("t3_latency", cyc, 32'd9);
    chk("t3_nwb", wa_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk("t3_wbaddr", wa_q[i], 32'h40 + 32'(4 * i));
    chk("t3_wd0", wd_q[0], 32'h1111_1111);
    chk("t3_wd1", wd_q[1], 32'hDEAD_BEEF);
    chk("t3_wd2", wd_q[2], 32'h3333_3333);
    chk("t3_wd3", wd_q[3], 32'h4444_4444);
    chk("t3_nrefill", rf_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk("t3_rfaddr", rf_q[i], 32'h440 + 32'(4 * i));
    chk("t3_rd", CpuRD, 32'h440 ^ 32'hC0DE_0000);

    // 4: clean conflict miss only refills
    cpu(1'b0, 32'h80, 32'h0);
    wait_ready(cyc);
    chk("t4a_latency", cyc, 32'd5);
    clear_logs();
    cpu(1'b0, 32'h480, 32'h0);
    wait_ready(cyc);
    chk("t4_latency", cyc, 32'd5);
    chk("t4_we_cycles", we_cycles, 32'd0);
    chk("t4_nrefill", rf_q.size(), 32'd4);
    chk("t4_rd", CpuRD, 32'h480 ^ 32'hC0DE_0000);

    // 5: reset after two refill acks aborts the transfer
    clear_logs();
    cpu(1'b0, 32'hC0, 32'h0);
    repeat (3) @(negedge CLK);
    chk("t5_pre_nrefill", rf_q.size(), 32'd2);
    Reset = 1'b1;
    #1 chk("t5_memreq", {31'd0, MemReq}, 32'd0);
    @(negedge CLK);
    Reset = 1'b0;
    clear_logs();
    wait_ready(cyc);
    chk("t5_latency", cyc, 32'd5);
    chk("t5_nrefill", rf_q.size(), 32'd4);
    chk("t5_rf0", rf_q[0], 32'hC0);
    chk("t5_rd", CpuRD, 32'hC0 ^ 32'hC0DE_0000);

    // 6: memory stalls mid-writeback; outputs must hold
    cpu(1'b1, 32'hC4, 32'hCAFE_F00D);
    @(negedge CLK);
    clear_logs();
    cpu(1'b0, 32'h4C0, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    ack_en = 1'b0;
    @(negedge CLK);
    hold_addr = MemAddr;
    hold_wd   = MemWD;
    chk("t6_addr", hold_addr, 32'hC8);
    chk("t6_wd", hold_wd, 32'hC8 ^ 32'hC0DE_0000);
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      chk("t6_hold_addr", MemAddr, 32'hC8);
      chk("t6_hold_wd", MemWD, 32'hC8 ^ 32'hC0DE_0000);
      chk("t6_hold_stall", {31'd0, Stall}, 32'd1);
    end
    ack_en = 1'b1;
    wait_ready(cyc);
    chk("t6_done", {31'd0, Stall}, 32'd0);
    chk("t6_nwb", wa_q.size(), 32'd4);
    chk("t6_wd1", wd_q[1], 32'hCAFE_F00D);
    chk("t6_rd", CpuRD, 32'h4C0 ^ 32'hC0DE_0000);

    CpuReq = 1'b0;
    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
